regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between the ALU (A) and long-latency (B)
// writeback ports, registered write onto the register file, and a busy scoreboard for hazards.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_ready,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        stall,
  output logic        rf_en,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [NREG-1:0] busy_q, busy_d;
  logic            last_grant_q, last_grant_d;
  logic            rf_en_q, rf_en_d;
  logic [AW-1:0]   rf_wa_q, rf_wa_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;

  logic a_elig, b_elig;
  logic a_grant, b_grant;
  logic haz1, haz2;

  // A must not overtake an outstanding B write to the same register
  always_comb begin
    a_elig  = a_valid && !busy_q[a_addr];
    b_elig  = b_valid;
    a_grant = a_elig && (!b_elig || (last_grant_q == GRANT_B));
    b_grant = b_elig && (!a_elig || (last_grant_q == GRANT_A));
  end

  // A source is unreadable while owed by B or while its write is still staged
  always_comb begin
    haz1 = (chk_addr1 != AW'(0)) &&
           (busy_q[chk_addr1] || (rf_en_q && (rf_wa_q == chk_addr1)));
    haz2 = (chk_addr2 != AW'(0)) &&
           (busy_q[chk_addr2] || (rf_en_q && (rf_wa_q == chk_addr2)));
  end

  assign a_ready   = a_grant;
  assign b_ready   = b_grant;
  assign iss_ready = !busy_q[iss_addr];
  assign stall     = haz1 || haz2;
  assign rf_en     = rf_en_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;

  always_comb begin
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    rf_en_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;

    if (a_grant) begin
      rf_en_d      = (a_addr != AW'(0));
      rf_wa_d      = a_addr;
      rf_wd_d      = a_data;
      last_grant_d = GRANT_A;
    end else if (b_grant) begin
      rf_en_d         = (b_addr != AW'(0));
      rf_wa_d         = b_addr;
      rf_wd_d         = b_data;
      last_grant_d    = GRANT_B;
      busy_d[b_addr]  = 1'b0;
    end

    // Set after clear so a same-cycle issue to the retiring register wins
    if (iss_valid && iss_ready && (iss_addr != AW'(0))) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      last_grant_q <= GRANT_B;
      rf_en_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      rf_en_q      <= rf_en_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset-mid-burst sequence,
// and randomized traffic checked against a scoreboard-level reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr, chk_addr1, chk_addr2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, iss_ready, stall, rf_en;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .stall(stall),
    .rf_en(rf_en), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        iv; logic [4:0] ia;
    logic [4:0]  c1; logic [4:0] c2;
    logic        e_ar, e_br, e_ir, e_st, e_en;
    logic [4:0]  e_wa; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(
      input logic av, input logic [4:0] aa, input logic [31:0] ad,
      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
      input logic iv, input logic [4:0] ia, input logic [4:0] c1, input logic [4:0] c2,
      input logic ear, input logic ebr, input logic eir, input logic est,
      input logic een, input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.iv = iv; v.ia = ia; v.c1 = c1; v.c2 = c2;
    v.e_ar = ear; v.e_br = ebr; v.e_ir = eir; v.e_st = est;
    v.e_en = een; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
  endtask

  // Reference model: register-file port and scoreboard as plain arrays
  bit          m_busy[32];
  bit          m_last_b;
  bit          m_en;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_last_b = 1; m_en = 0; m_wa = 0; m_wd = 0;
  endtask

  function automatic bit m_haz(input logic [4:0] r);
    return (r != 0) && (m_busy[r] || (m_en && m_wa == r));
  endfunction

  task automatic model_check_step(input int cyc);
    bit ea, eb, ga, gb, isr, st;
    ea  = a_valid && !m_busy[a_addr];
    eb  = b_valid;
    if (ea && eb) begin ga = m_last_b; gb = !m_last_b; end
    else begin ga = ea; gb = eb; end
    isr = (iss_addr == 0) || !m_busy[iss_addr];
    st  = m_haz(chk_addr1) || m_haz(chk_addr2);
    check($sformatf("rnd%0d a_ready", cyc), 32'(a_ready), 32'(ga));
    check($sformatf("rnd%0d b_ready", cyc), 32'(b_ready), 32'(gb));
    check($sformatf("rnd%0d iss_ready", cyc), 32'(iss_ready), 32'(isr));
    check($sformatf("rnd%0d stall", cyc), 32'(stall), 32'(st));
    check($sformatf("rnd%0d rf_en", cyc), 32'(rf_en), 32'(m_en));
    check($sformatf("rnd%0d rf_wa", cyc), 32'(rf_wa), 32'(m_wa));
    check($sformatf("rnd%0d rf_wd", cyc), rf_wd, m_wd);
    m_en = 0;
    if (ga) begin
      m_en = (a_addr != 0); m_wa = a_addr; m_wd = a_data; m_last_b = 0;
    end else if (gb) begin
      m_en = (b_addr != 0); m_wa = b_addr; m_wd = b_data; m_last_b = 1;
      m_busy[b_addr] = 0;
    end
    if (iss_valid && isr && iss_addr != 0) m_busy[iss_addr] = 1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0,1,0, 0,0,32'h0);
    tbl[1]  = mk(1,5,32'h1234,0,0,0,       0,0, 5,0, 1,0,1,0, 0,0,32'h0);
    tbl[2]  = mk(0,0,0,       0,0,0,       0,0, 5,0, 0,0,1,1, 1,5,32'h1234);
    tbl[3]  = mk(0,0,0,       0,0,0,       0,0, 5,0, 0,0,1,0, 0,5,32'h1234);
    tbl[4]  = mk(0,0,0,       1,9,32'h99,  0,0, 0,0, 0,1,1,0, 0,5,32'h1234);
    tbl[5]  = mk(1,1,32'h11,  1,2,32'h22,  0,0, 0,0, 1,0,1,0, 1,9,32'h99);
    tbl[6]  = mk(1,1,32'h11,  1,2,32'h22,  0,0, 0,0, 0,1,1,0, 1,1,32'h11);
    tbl[7]  = mk(1,1,32'h11,  1,2,32'h22,  0,0, 0,0, 1,0,1,0, 1,2,32'h22);
    tbl[8]  = mk(1,1,32'h11,  1,2,32'h22,  0,0, 0,0, 0,1,1,0, 1,1,32'h11);
    tbl[9]  = mk(0,0,0,       0,0,0,       0,0, 0,0, 0,0,1,0, 1,2,32'h22);
    tbl[10] = mk(0,0,0,       0,0,0,       1,7, 7,0, 0,0,1,0, 0,2,32'h22);
    tbl[11] = mk(1,7,32'hAAAA,0,0,0,       0,7, 7,0, 0,0,0,1, 0,2,32'h22);
    tbl[12] = mk(1,7,32'hAAAA,1,7,32'hBEEF,0,7, 7,0, 0,1,0,1, 0,2,32'h22);
    tbl[13] = mk(1,7,32'hAAAA,0,0,0,       0,7, 7,0, 1,0,1,1, 1,7,32'hBEEF);
    tbl[14] = mk(0,0,0,       0,0,0,       0,0, 7,0, 0,0,1,1, 1,7,32'hAAAA);
    tbl[15] = mk(0,0,0,       0,0,0,       0,0, 7,0, 0,0,1,0, 0,7,32'hAAAA);
    tbl[16] = mk(0,0,0,       1,3,32'h33,  1,3, 3,0, 0,1,1,0, 0,7,32'hAAAA);
    tbl[17] = mk(0,0,0,       0,0,0,       1,3, 3,0, 0,0,0,1, 1,3,32'h33);
    tbl[18] = mk(1,0,32'hFFFF,0,0,0,       1,0, 3,0, 1,0,1,1, 0,3,32'h33);
    tbl[19] = mk(0,0,0,       0,0,0,       0,0, 0,3, 0,0,1,1, 0,0,32'hFFFF);

    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("reset rf_en", 32'(rf_en), 32'd0);
    check("reset rf_wa", 32'(rf_wa), 32'd0);
    check("reset rf_wd", rf_wd, 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset iss_ready", 32'(iss_ready), 32'd1);
    rst_n = 1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      iss_valid = tbl[i].iv; iss_addr = tbl[i].ia;
      chk_addr1 = tbl[i].c1; chk_addr2 = tbl[i].c2;
      #1;
      check($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(tbl[i].e_ar));
      check($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(tbl[i].e_br));
      check($sformatf("v%0d iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_ir));
      check($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].e_st));
      check($sformatf("v%0d rf_en", i), 32'(rf_en), 32'(tbl[i].e_en));
      check($sformatf("v%0d rf_wa", i), 32'(rf_wa), 32'(tbl[i].e_wa));
      check($sformatf("v%0d rf_wd", i), rf_wd, tbl[i].e_wd);
    end

    // Reset asserted while a write is staged and x3 is still busy
    @(negedge clk);
    idle_inputs();
    a_valid = 1; a_addr = 4; a_data = 32'h44; chk_addr1 = 3; iss_addr = 3;
    @(negedge clk);
    #1;
    check("burst rf_en", 32'(rf_en), 32'd1);
    check("burst stall", 32'(stall), 32'd1);
    rst_n = 0;
    #1;
    check("midrst rf_en", 32'(rf_en), 32'd0);
    check("midrst rf_wa", 32'(rf_wa), 32'd0);
    check("midrst rf_wd", rf_wd, 32'd0);
    check("midrst stall", 32'(stall), 32'd0);
    check("midrst iss_ready", 32'(iss_ready), 32'd1);
    check("midrst a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    model_reset();

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a_valid   = 1'($urandom_range(0, 1));
      a_addr    = 5'($urandom_range(0, 7));
      a_data    = $urandom;
      b_valid   = 1'($urandom_range(0, 1));
      b_addr    = 5'($urandom_range(0, 7));
      b_data    = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 7));
      chk_addr1 = 5'($urandom_range(0, 7));
      chk_addr2 = 5'($urandom_range(0, 7));
      #1;
      model_check_step(c);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
